// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter on the CPU data bus.
// Stores to TXDATA are queued in a small FIFO and sent on TX as 8N1 frames.
// STATUS exposes {OVF, BUSY, FULL, EMPTY}; a store to STATUS clears OVF.
module mmio_uart_tx #(
    parameter logic [7:0] BASE         = 8'hF0,
    parameter int         DEPTH        = 4,
    parameter int         CLKS_PER_BIT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] ADDR,
    input  logic [7:0] WD,
    input  logic       WE,
    output logic [7:0] RD,
    output logic       SEL,
    output logic       TX,
    output logic       BUSY
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    logic sel_data, sel_stat, full, empty, push, pop, baud_last;

    assign sel_data  = (ADDR == BASE);
    assign sel_stat  = (ADDR == BASE + 8'd1);
    assign SEL       = sel_data | sel_stat;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    // FULL is judged on the pre-edge count, so a same-edge pop never admits a write
    assign push      = WE & sel_data & ~full;
    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign BUSY      = (state_q != S_IDLE);
    assign TX        = tx_q;

    // Register read mux; unmapped addresses and TXDATA read as zero
    always_comb begin
        RD = 8'h00;
        if (sel_stat) RD = {4'b0000, ovf_q, BUSY, full, empty};
    end

    // Overflow flag: set by a store into a full FIFO, cleared by any store to STATUS
    always_comb begin
        ovf_d = ovf_q;
        if (WE && sel_stat)                ovf_d = 1'b0;
        else if (WE && sel_data && full)   ovf_d = 1'b1;
    end

    // Serialiser next state; TX is derived from the next state so the flop never glitches
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                if (baud_last) begin
                    baud_d = '0;
                    // back-to-back frames: the next start bit follows the stop bit directly
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO occupancy: simultaneous push and pop leave the count unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    // FIFO storage holds data only, so it carries no reset
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= WD;
    end

    // Shift register holds data only; its contents are don't-care outside a frame
    always_ff @(posedge CLK) begin
        shift_q <= shift_d;
    end

    // Control state: reset aborts any frame and discards queued bytes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            tx_q     <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed register/frame scenarios plus random bus
// traffic, all compared against a frame-level reference model of the line.
module tb_mmio_uart_tx;

    localparam logic [7:0] BASE  = 8'hF0;
    localparam int         DEPTH = 4;
    localparam int         CPB   = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] ADDR = 8'h00;
    logic [7:0] WD = 8'h00;
    logic       WE = 1'b0;
    logic [7:0] RD;
    logic       SEL, TX, BUSY;

    int n_chk = 0;
    int n_err = 0;

    mmio_uart_tx #(.BASE(BASE), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .WD(WD), .WE(WE),
        .RD(RD), .SEL(SEL), .TX(TX), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted bytes and the frame currently on the line.
    // A frame is 10 symbols (start, 8 data LSB first, stop), each CPB cycles long.
    logic [7:0]  mq [$];
    int          rem;      // cycles of the current frame still to be shown (0 = line idle)
    int          pos;      // cycle index within the current frame
    logic [9:0]  frame;
    logic        m_ovf;
    logic        was_full;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mq.delete();
            rem   = 0;
            pos   = 0;
            m_ovf = 1'b0;
            frame = 10'h3FF;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (rem > 0) rem--;
            if (rem > 0) pos++;
            else if (mq.size() > 0) begin
                frame = {1'b1, mq.pop_front(), 1'b0};
                rem   = 10 * CPB;
                pos   = 0;
            end
            if (WE && ADDR == BASE) begin
                if (was_full) m_ovf = 1'b1;
                else          mq.push_back(WD);
            end
            if (WE && ADDR == BASE + 8'd1) m_ovf = 1'b0;
        end
    end

    function automatic logic exp_tx();
        return (rem > 0) ? frame[pos / CPB] : 1'b1;
    endfunction

    function automatic logic [7:0] exp_rd();
        logic [7:0] v;
        v = 8'h00;
        if (ADDR == BASE + 8'd1)
            v = {4'b0000, m_ovf, rem > 0, mq.size() == DEPTH, mq.size() == 0};
        return v;
    endfunction

    // Mid-cycle comparison of every output against the model
    always @(negedge CLK) begin
        if (!RST) begin
            chk("tx",   {31'b0, TX},   {31'b0, exp_tx()});
            chk("busy", {31'b0, BUSY}, {31'b0, logic'(rem > 0)});
            chk("sel",  {31'b0, SEL},  {31'b0, logic'(ADDR == BASE || ADDR == BASE + 8'd1)});
            chk("rd",   {24'b0, RD},   {24'b0, exp_rd()});
        end
    end

    // Present one bus cycle; it is sampled at the following rising edge
    task automatic cyc(input logic [7:0] a, input logic [7:0] d, input logic w);
        @(posedge CLK);
        #2;
        ADDR = a;
        WD   = d;
        WE   = w;
    endtask

    task automatic idle(input int n, input logic [7:0] a);
        for (int i = 0; i < n; i++) cyc(a, 8'h00, 1'b0);
    endtask

    logic [7:0] a5 = 8'hA5;
    logic       e;
    int         r;

    initial begin
        // Reset then idle
        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        idle(20, BASE + 8'd1);
        #1;
        chk("rst_status", {24'b0, RD}, 32'h01);
        chk("rst_tx",     {31'b0, TX}, 32'h1);

        // Single byte A5 with explicit frame timing
        cyc(BASE, 8'hA5, 1'b1);
        cyc(BASE + 8'd1, 8'h00, 1'b0);
        for (int k = 1; k <= 41; k++) begin
            @(posedge CLK);
            #1;
            if (k <= 4)       e = 1'b0;
            else if (k <= 36) e = a5[(k - 5) / 4];
            else              e = 1'b1;
            chk("a5_tx", {31'b0, TX}, {31'b0, e});
            if (k == 1)  chk("a5_busy_rise", {31'b0, BUSY}, 32'h1);
            if (k == 40) chk("a5_busy_stop", {31'b0, BUSY}, 32'h1);
            if (k == 41) chk("a5_busy_fall", {31'b0, BUSY}, 32'h0);
        end
        idle(5, BASE + 8'd1);

        // Back-to-back frames
        cyc(BASE, 8'h01, 1'b1);
        cyc(BASE, 8'hFF, 1'b1);
        idle(90, BASE + 8'd1);

        // Full and overflow
        cyc(BASE, 8'h11, 1'b1);
        idle(3, BASE + 8'd1);
        cyc(BASE, 8'h22, 1'b1);
        cyc(BASE, 8'h33, 1'b1);
        cyc(BASE, 8'h44, 1'b1);
        cyc(BASE, 8'h55, 1'b1);
        cyc(BASE, 8'h66, 1'b1);
        cyc(BASE + 8'd1, 8'h00, 1'b0);
        #1 chk("ovf_status", {24'b0, RD}, 32'h0E);
        cyc(BASE + 8'd1, 8'hAB, 1'b1);
        cyc(BASE + 8'd1, 8'h00, 1'b0);
        #1 chk("ovf_clear", {24'b0, RD}, 32'h06);
        idle(5 * 10 * CPB + 10, BASE + 8'd1);

        // Address decode
        cyc(BASE + 8'd2, 8'h55, 1'b1);
        #1 chk("dec_sel_f2", {31'b0, SEL}, 32'h0);
        cyc(BASE, 8'h00, 1'b0);
        #1 chk("dec_rd_f0", {24'b0, RD}, 32'h00);
        chk("dec_sel_f0", {31'b0, SEL}, 32'h1);
        idle(10, BASE + 8'd1);
        #1 chk("dec_status", {24'b0, RD}, 32'h01);

        // Reset in the middle of the third data bit of 3C
        cyc(BASE, 8'h3C, 1'b1);
        cyc(BASE + 8'd1, 8'h00, 1'b0);
        repeat (14) @(posedge CLK);
        #2;
        chk("mid_busy_pre", {31'b0, BUSY}, 32'h1);
        RST = 1'b1;
        #1;
        chk("mid_tx",   {31'b0, TX},   32'h1);
        chk("mid_busy", {31'b0, BUSY}, 32'h0);
        @(posedge CLK);
        #2 RST = 1'b0;
        idle(50, BASE + 8'd1);
        #1 chk("mid_status", {24'b0, RD}, 32'h01);

        // Random bus traffic
        for (int i = 0; i < 700; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: cyc(BASE, 8'($urandom), $urandom_range(0, 3) == 0);
                3:       cyc(BASE + 8'd1, 8'($urandom), $urandom_range(0, 5) == 0);
                4:       cyc(BASE + 8'd2, 8'($urandom), 1'b1);
                5:       cyc(8'($urandom), 8'($urandom), 1'($urandom));
                default: cyc(BASE + 8'd1, 8'h00, 1'b0);
            endcase
        end
        idle((DEPTH + 1) * 10 * CPB + 10, BASE + 8'd1);
        #1 chk("drain_idle", {31'b0, BUSY}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped responder on the CPU data-memory bus: address, write data, write enable and read data, the same bus the CPU drives toward RAM.
- The CPU stores a byte to the data register. The block queues it in a small FIFO and serialises it on a UART-style TX line as 8N1.
- A status register lets software poll before storing.
- The top level selects this block's read data instead of RAM read data whenever SEL is high.

Parameters:
- BASE, 8'hF0, base address. The block decodes BASE (TXDATA) and BASE+1 (STATUS).
- DEPTH, 4, FIFO entries. Power of two, ≥2.
- CLKS_PER_BIT, 4, CLK cycles per serial bit. ≥1.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge
- RST  input  1  asynchronous, active-high reset
- ADDR  input  8  bus address (CPU D1)
- WD  input  8  bus write data (CPU ALU result)
- WE  input  1  bus write enable (CPU RAM_WE)
- RD  output  8  read data, combinational from ADDR and state
- SEL  output  1  combinational; 1 when ADDR == BASE or BASE+1
- TX  output  1  serial line, registered, idle high
- BUSY  output  1  1 when the serialiser is not IDLE

Behaviour:
- Reset (async, RST=1):
  - FIFO is emptied: rd/wr pointers 0, count 0.
  - State = IDLE, TX=1, BUSY=0, overflow flag = 0, baud and bit counters = 0.
  - Reset mid-frame aborts the frame immediately: TX returns to 1 and queued data is lost.
- Register map:
  - Read of TXDATA returns 8'h00.
  - Read of STATUS returns {4'b0, OVF, BUSY, FULL, EMPTY}.
  - RD = 8'h00 when SEL=0.
- Writes: sampled on the rising CLK when WE=1.
  - To TXDATA with FULL=0: push WD; count+1 at that edge.
  - To TXDATA with FULL=1: data dropped, OVF set to 1 (sticky). FULL is evaluated before the edge, so a pop on the same edge does not admit the write.
  - To STATUS (any data): clears OVF.
  - Writes to other addresses are ignored.
- FIFO:
  - Circular; pointers wrap modulo DEPTH.
  - FULL = (count == DEPTH), EMPTY = (count == 0).
  - A push and a pop on the same edge (not full) leave count unchanged.
- Serialiser FSM: IDLE, START, DATA, STOP.
  - IDLE: TX=1. At the edge where EMPTY=0, pop the head into the shift register and go to START.
  - START: TX=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: TX = shift[0] for CLKS_PER_BIT cycles per bit, LSB first; shift right after each bit. After bit 7 go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles. On its last cycle:
    - if EMPTY=0, pop and go directly to START (back-to-back, no idle gap);
    - else go to IDLE.
  - A frame is exactly 10*CLKS_PER_BIT cycles long.
- Latency: a write to an empty FIFO with the FSM in IDLE at edge N gives the pop at edge N+1. TX falls after edge N+1 and BUSY rises after edge N+1.
- TX is a flop driven from FSM state and shift[0]; it never glitches.

Test Plan (CLKS_PER_BIT=4, DEPTH=4, BASE=F0):
- Reset then idle: RST pulse, run 20 cycles → TX=1, BUSY=0, read F1 → 8'h01.
- Single byte: write F0=8'hA5 at edge N → TX=0 for edges N+1..N+4. Then bits 1,0,1,0,0,1,0,1 each held 4 cycles. TX=1 for 4 cycles, BUSY=0 after edge N+41.
- Back-to-back: write 8'h01 then 8'hFF on consecutive cycles → two 40-cycle frames with no idle cycle between them. The STOP bit of frame 1 is followed directly by the START bit of frame 2.
- Full/overflow: while frame 1 is in progress, write 5 more bytes quickly. After 4 are queued, read F1 → bit1 FULL=1. The 5th write sets OVF → F1 reads 8'h0E. Write F1 → OVF cleared (8'h06). All 4 queued bytes are transmitted in order and the dropped byte never appears.
- Address decode: write F2=8'h55 with WE=1 → SEL=0, FIFO unchanged, TX stays 1. Read F0 → RD=8'h00, SEL=1.
- Reset mid-frame: assert RST at the 3rd data bit of 8'h3C → TX=1 and BUSY=0 immediately (asynchronously). After release, F1 reads 8'h01 and no residual frame is sent.
